// File: rtl/axis_frame_trim_fifo_if.sv
// AXI-Stream link used on both sides of the trim FIFO.
// The master drives data/valid/last; the slave drives ready.
interface axis_frame_trim_fifo_if #(
  parameter int Data_width = 16
);
  logic [Data_width-1:0] data;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_frame_trim_fifo.sv
// Re-framing FIFO: drops the first k beats of each frame, caps frames at len beats and
// regenerates last; output is either cut-through or whole-frame store-and-forward.
module axis_frame_trim_fifo #(
  parameter int Data_width = 16,
  parameter int Depth      = 16,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_frame_trim_fifo_if.slave  s_axis,
  axis_frame_trim_fifo_if.master m_axis,
  input  logic [Cnt_width-1:0]  k,
  input  logic [Cnt_width-1:0]  len,
  input  logic                  sf_mode,
  output logic                  full,
  output logic                  empty,
  output logic [Cnt_width-1:0]  level,
  output logic                  frame_drop
);

  localparam int                   Ptr_width = $clog2(Depth);
  localparam logic [Cnt_width-1:0] Depth_c   = Cnt_width'(Depth);
  localparam logic [Cnt_width-1:0] Idx_max   = '1;
  localparam logic [Cnt_width-1:0] One_c     = Cnt_width'(1);
  localparam logic [Ptr_width-1:0] Ptr_one   = Ptr_width'(1);

  logic [Data_width:0]    mem [Depth];
  logic [Ptr_width-1:0]   wr_ptr, rd_ptr;
  logic [Cnt_width-1:0]   count, frames, idx;
  logic [Cnt_width-1:0]   cfg_k, cfg_len;
  logic                   cfg_sf;

  logic                   first_beat, drop, eof, accept, wr_en, rd_en;
  logic [Cnt_width-1:0]   eff_k, eff_len;

  // The first beat of a frame is judged with the live config; later beats use the latch.
  assign first_beat = (idx == '0);
  assign eff_k      = first_beat ? k   : cfg_k;
  assign eff_len    = first_beat ? len : cfg_len;

  assign drop  = (idx < eff_k);
  assign eof   = s_axis.last || ((eff_len != '0) && (idx == (eff_len - One_c)));

  assign full  = (count == Depth_c);
  assign empty = (count == '0);
  assign level = count;

  // Dropped beats are always absorbed, even while the buffer is full.
  assign s_axis.ready = !rst && (drop || !full);
  assign accept       = s_axis.valid && s_axis.ready;
  assign wr_en        = accept && !drop;

  // The full term releases an oversized frame so store-and-forward cannot deadlock.
  assign m_axis.valid = !empty && (!cfg_sf || (frames != '0) || full);
  assign m_axis.data  = mem[rd_ptr][Data_width-1:0];
  assign m_axis.last  = m_axis.valid && mem[rd_ptr][Data_width];
  assign rd_en        = m_axis.valid && m_axis.ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {eof, s_axis.data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frames     <= '0;
      idx        <= '0;
      cfg_k      <= '0;
      cfg_len    <= '0;
      cfg_sf     <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= accept && eof && drop;

      if (accept) begin
        if (first_beat) begin
          cfg_k   <= k;
          cfg_len <= len;
          cfg_sf  <= sf_mode;
        end
        if (eof)                 idx <= '0;
        else if (idx != Idx_max) idx <= idx + One_c;
      end

      if (wr_en) wr_ptr <= wr_ptr + Ptr_one;
      if (rd_en) rd_ptr <= rd_ptr + Ptr_one;

      case ({wr_en, rd_en})
        2'b10:   count <= count + One_c;
        2'b01:   count <= count - One_c;
        default: count <= count;
      endcase

      case ({wr_en && eof, rd_en && m_axis.last})
        2'b10:   frames <= frames + One_c;
        2'b01:   frames <= frames - One_c;
        default: frames <= frames;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_trim_fifo.sv
// Bench for axis_frame_trim_fifo: directed scenarios plus a randomized run, all checked
// cycle by cycle against a queue-based model of the trimming/framing rules.
module tb_axis_frame_trim_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] k   = '0;
  logic [CW-1:0] len = '0;
  logic          sf_mode = 1'b0;
  logic          full, empty, frame_drop;
  logic [CW-1:0] level;

  axis_frame_trim_fifo_if #(.Data_width(DW)) s_if ();
  axis_frame_trim_fifo_if #(.Data_width(DW)) m_if ();

  axis_frame_trim_fifo #(.Data_width(DW), .Depth(DEPTH), .Cnt_width(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .k          (k),
    .len        (len),
    .sf_mode    (sf_mode),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW:0] mq[$];
  int          m_idx;
  int          c_k, c_len;
  bit          c_sf;
  bit          exp_fd;

  // observation logs
  logic [DW:0] out_log[$];
  int          out_cyc[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          fd_cnt = 0;
  int          mv_cnt = 0;

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    c_k    = 0;
    c_len  = 0;
    c_sf   = 1'b0;
    exp_fd = 1'b0;
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    acc_cyc.delete();
    acc_cnt = 0;
    fd_cnt  = 0;
    mv_cnt  = 0;
  endtask

  // One clock: drive inputs, check outputs mid-cycle against the model, advance the model.
  task automatic clk_step(input bit v, input logic [DW-1:0] d, input bit l, input bit mr);
    int ek, el, nl;
    bit drop, efull, esr, emv, eof;
    s_if.valid  = v;
    s_if.data   = d;
    s_if.last   = l;
    m_if.ready  = mr;
    @(negedge clk);
    ek    = (m_idx == 0) ? int'(k)   : c_k;
    el    = (m_idx == 0) ? int'(len) : c_len;
    drop  = (m_idx < ek);
    efull = (mq.size() == DEPTH);
    nl    = 0;
    foreach (mq[i]) if (mq[i][DW]) nl++;
    esr   = drop || !efull;
    emv   = (mq.size() != 0) && (!c_sf || nl > 0 || efull);

    total++;
    if (s_if.ready !== esr) begin
      bad++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_if.ready, esr);
    end
    total++;
    if (m_if.valid !== emv) begin
      bad++;
      $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_if.valid, emv);
    end
    total++;
    if (level !== CW'(mq.size())) begin
      bad++;
      $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, mq.size());
    end
    total++;
    if (full !== efull || empty !== (mq.size() == 0)) begin
      bad++;
      $display("FAIL full_empty cyc=%0d got=%b%b exp=%b%b", cyc, full, empty, efull, mq.size() == 0);
    end
    total++;
    if (frame_drop !== exp_fd) begin
      bad++;
      $display("FAIL frame_drop cyc=%0d got=%b exp=%b", cyc, frame_drop, exp_fd);
    end
    if (emv) begin
      total++;
      if ({m_if.last, m_if.data} !== mq[0]) begin
        bad++;
        $display("FAIL m_beat cyc=%0d got=%b/%h exp=%b/%h", cyc, m_if.last, m_if.data,
                 mq[0][DW], mq[0][DW-1:0]);
      end
    end

    if (frame_drop === 1'b1) fd_cnt++;
    if (m_if.valid === 1'b1) mv_cnt++;

    if (emv && mr) begin
      out_log.push_back({m_if.last, m_if.data});
      out_cyc.push_back(cyc);
      void'(mq.pop_front());
    end
    exp_fd = 1'b0;
    if (v && esr) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      eof = l || (el != 0 && m_idx == el - 1);
      exp_fd = eof && drop;
      if (m_idx == 0) begin
        c_k   = int'(k);
        c_len = int'(len);
        c_sf  = sf_mode;
      end
      if (!drop) mq.push_back({eof, d});
      if (eof)                m_idx = 0;
      else if (m_idx < 65535) m_idx = m_idx + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (mq.size() != 0 && n < max_cyc) begin
      clk_step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    total++;
    if (mq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d", mq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = '1;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_if.valid !== 1'b0 || m_if.last !== 1'b0) begin
      bad++;
      $display("FAIL reset_mout got=%b%b exp=00", m_if.valid, m_if.last);
    end
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== '0) begin
      bad++;
      $display("FAIL reset_status got e=%b f=%b l=%0d exp e=1 f=0 l=0", empty, full, level);
    end
    total++;
    if (frame_drop !== 1'b0 || s_if.ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_misc got fd=%b srdy=%b exp 0 0", frame_drop, s_if.ready);
    end
    rst = 1'b0;
    s_if.valid = 1'b0;
    model_reset();
    clk_step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_cut_through();
    clear_logs();
    sf_mode = 1'b0; k = 16'd4; len = 16'd10;
    for (int i = 0; i < 10; i++) clk_step(1'b1, DW'(2 * (i + 1)), 1'b0, 1'b1);
    drain(20);
    total++;
    if (out_log.size() != 6) begin
      bad++;
      $display("FAIL ct_count got=%0d exp=6", out_log.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        total++;
        if (out_log[j] !== {j == 5, DW'(10 + 2 * j)}) begin
          bad++;
          $display("FAIL ct_beat%0d got=%h exp=%b/%0d", j, out_log[j], j == 5, 10 + 2 * j);
        end
      end
      total++;
      if (out_cyc[0] != acc_cyc[4] + 1) begin
        bad++;
        $display("FAIL ct_latency got=%0d exp=%0d", out_cyc[0], acc_cyc[4] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    sf_mode = 1'b0; k = 16'd0; len = 16'd0;
    for (int i = 0; i < 15; i++) clk_step(1'b1, DW'(100 + i), (i % 5) == 4, 1'b1);
    drain(20);
    total++;
    if (out_log.size() != 15) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=15", out_log.size());
    end else begin
      for (int j = 0; j < 15; j++) begin
        total++;
        if (out_log[j] !== {(j % 5) == 4, DW'(100 + j)}) begin
          bad++;
          $display("FAIL b2b_beat%0d got=%h exp=%b/%0d", j, out_log[j], (j % 5) == 4, 100 + j);
        end
      end
    end
  endtask

  task automatic test_all_drop();
    clear_logs();
    sf_mode = 1'b0; k = 16'd12; len = 16'd10;
    for (int i = 0; i < 20; i++) clk_step(1'b1, DW'(500 + i), 1'b0, 1'b1);
    repeat (3) clk_step(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (fd_cnt != 2 || mv_cnt != 0 || acc_cnt != 20) begin
      bad++;
      $display("FAIL drop_frames got fd=%0d mv=%0d acc=%0d exp fd=2 mv=0 acc=20",
               fd_cnt, mv_cnt, acc_cnt);
    end
  endtask

  task automatic test_store_forward();
    clear_logs();
    sf_mode = 1'b1; k = 16'd2; len = 16'd8;
    for (int i = 0; i < 8; i++) clk_step(1'b1, DW'(700 + i), 1'b0, 1'b1);
    drain(20);
    total++;
    if (out_log.size() != 6 || acc_cyc.size() != 8) begin
      bad++;
      $display("FAIL sf_count got=%0d exp=6", out_log.size());
    end else begin
      total++;
      if (out_cyc[0] != acc_cyc[7] + 1 || out_cyc[5] - out_cyc[0] != 5) begin
        bad++;
        $display("FAIL sf_release got first=%0d span=%0d exp first=%0d span=5",
                 out_cyc[0], out_cyc[5] - out_cyc[0], acc_cyc[7] + 1);
      end
      total++;
      if (out_log[5] !== {1'b1, DW'(707)} || out_log[0] !== {1'b0, DW'(702)}) begin
        bad++;
        $display("FAIL sf_data got=%h..%h exp=0/702..1/707", out_log[0], out_log[5]);
      end
    end
    sf_mode = 1'b0;
  endtask

  task automatic test_full();
    clear_logs();
    sf_mode = 1'b0; k = 16'd0; len = 16'd0;
    for (int i = 0; i < 20; i++) clk_step(1'b1, DW'(200 + acc_cnt), 1'b0, 1'b0);
    total++;
    if (level !== 16'd16 || full !== 1'b1 || s_if.ready !== 1'b0 || acc_cnt != 16) begin
      bad++;
      $display("FAIL full_state got lvl=%0d full=%b srdy=%b acc=%0d exp 16 1 0 16",
               level, full, s_if.ready, acc_cnt);
    end
    clk_step(1'b1, DW'(200 + acc_cnt), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) clk_step(1'b1, DW'(200 + acc_cnt), 1'b0, 1'b0);
    total++;
    if (acc_cnt != 17 || level !== 16'd16) begin
      bad++;
      $display("FAIL full_one_slot got acc=%0d lvl=%0d exp acc=17 lvl=16", acc_cnt, level);
    end
    drain(40);
    clk_step(1'b1, DW'(999), 1'b1, 1'b1);
    drain(10);
    total++;
    if (out_log.size() != 18) begin
      bad++;
      $display("FAIL full_order_count got=%0d exp=18", out_log.size());
    end else begin
      for (int j = 0; j < 17; j++) begin
        total++;
        if (out_log[j][DW-1:0] !== DW'(200 + j)) begin
          bad++;
          $display("FAIL full_order%0d got=%0d exp=%0d", j, out_log[j][DW-1:0], 200 + j);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    sf_mode = 1'b0; k = 16'd2; len = 16'd0;
    for (int i = 0; i < 5; i++) clk_step(1'b1, DW'(300 + i), 1'b0, 1'b0);
    total++;
    if (level !== 16'd3) begin
      bad++;
      $display("FAIL mid_level got=%0d exp=3", level);
    end
    rst = 1'b1;
    s_if.valid = 1'b1;
    m_if.ready = 1'b0;
    @(negedge clk);
    total++;
    if (s_if.ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_sready got=%b exp=0", s_if.ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_if.valid = 1'b0;
    model_reset();
    total++;
    if (empty !== 1'b1 || m_if.valid !== 1'b0 || level !== '0) begin
      bad++;
      $display("FAIL rst_mid got e=%b mv=%b lvl=%0d exp 1 0 0", empty, m_if.valid, level);
    end
    clear_logs();
    for (int i = 0; i < 5; i++) clk_step(1'b1, DW'(400 + i), i == 4, 1'b1);
    drain(10);
    total++;
    if (out_log.size() != 3) begin
      bad++;
      $display("FAIL rst_next_count got=%0d exp=3", out_log.size());
    end else begin
      total++;
      if (out_log[0] !== {1'b0, DW'(402)} || out_log[2] !== {1'b1, DW'(404)}) begin
        bad++;
        $display("FAIL rst_next_data got=%h..%h exp=0/402..1/404", out_log[0], out_log[2]);
      end
    end
  endtask

  task automatic test_random();
    bit stall = 1'b0;
    int n;
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        k       = CW'($urandom_range(0, 5));
        len     = CW'($urandom_range(0, 9));
        sf_mode = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 49) == 0) stall = ~stall;
      clk_step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 5) == 0,
               !stall && $urandom_range(0, 2) != 0);
    end
    n = 0;
    while (m_idx != 0 && n < 60) begin
      clk_step(1'b1, DW'($urandom), 1'b1, 1'b1);
      n++;
    end
    total++;
    if (m_idx != 0) begin
      bad++;
      $display("FAIL rand_close_timeout idx=%0d", m_idx);
    end
    drain(100);
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    model_reset();
    test_reset();
    test_cut_through();
    test_back_to_back();
    test_all_drop();
    test_store_forward();
    test_full();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
